// File: rtl/add_approx_if.sv
// Operand/result handshake bundle for add_approx_pipe.
// Master drives operands and out_ready. Slave drives in_ready and the results.
interface add_approx_if #(
    parameter int WIDTH = 8,
    parameter int MAX_K = 4
);
    localparam int KW = $clog2(MAX_K + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic [KW-1:0]    in_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [WIDTH:0]   out_err;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_k, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_k, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/add_approx_pipe.sv
// Pipelined approximate unsigned adder with per-transaction mode/k and a
// run-time error monitor measured against the exact sum.
module add_approx_pipe #(
    parameter int WIDTH  = 8,
    parameter int MAX_K  = 4,
    parameter int STAGES = 2,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    add_approx_if.slave      bus,
    input  logic             stats_clr,
    output logic [ACC_W-1:0] err_cnt,
    output logic [ACC_W-1:0] txn_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [WIDTH:0]   err_max
);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int SW = WIDTH + 1;

    // Handshake: a beat moves when valid & ready are both high at a rising
    // edge; valid never depends on ready, and in_ready = !stall combinationally.
    logic stall;
    logic accept;
    logic xfer;

    logic [KW-1:0] k_eff;
    logic [IW-1:0] k_idx;
    logic [SW-1:0] ax, bx, mask, hi_sum, exact_sum, approx_sum, abs_err;
    logic          cin;

    logic          v_q   [STAGES];
    logic [SW-1:0] sum_q [STAGES];
    logic [SW-1:0] err_q [STAGES];

    always_comb begin
        k_eff = (bus.in_k > KW'(MAX_K)) ? KW'(MAX_K) : bus.in_k;
        k_idx = IW'(k_eff - 1'b1);
        ax        = {1'b0, bus.in_a};
        bx        = {1'b0, bus.in_b};
        exact_sum = ax + bx;
        mask      = (SW'(1) << k_eff) - SW'(1);
        hi_sum    = (ax >> k_eff) + (bx >> k_eff);
        cin       = 1'b0;
        if (k_eff != '0) cin = bus.in_a[k_idx] & bus.in_b[k_idx];
        case (bus.in_mode)
            2'd0:    approx_sum = exact_sum;
            2'd1:    approx_sum = ((hi_sum + SW'(cin)) << k_eff) | ((ax | bx) & mask);
            2'd2:    approx_sum = hi_sum << k_eff;
            // low k bits of the full sum are exactly (a_L + b_L) mod 2^k
            default: approx_sum = (hi_sum << k_eff) | (exact_sum & mask);
        endcase
        abs_err = (approx_sum > exact_sum) ? (approx_sum - exact_sum)
                                           : (exact_sum - approx_sum);
    end

    assign stall         = v_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign accept        = bus.in_valid & bus.in_ready;
    assign xfer          = v_q[STAGES-1] & bus.out_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_sum   = sum_q[STAGES-1];
    assign bus.out_err   = err_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i]   <= 1'b0;
                sum_q[i] <= '0;
                err_q[i] <= '0;
            end
        end else if (!stall) begin
            v_q[0]   <= accept;
            sum_q[0] <= approx_sum;
            err_q[0] <= abs_err;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i]   <= v_q[i-1];
                sum_q[i] <= sum_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    logic [ACC_W:0] sum_ext;
    assign sum_ext = {1'b0, err_sum} + (ACC_W + 1)'(bus.out_err);

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            err_cnt <= '0;
            txn_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
        end else if (xfer) begin
            if (txn_cnt != '1) txn_cnt <= txn_cnt + 1'b1;
            if ((bus.out_err != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (bus.out_err > err_max) err_max <= bus.out_err;
        end
    end
endmodule

// File: tb/tb_add_approx_pipe.sv
// Self-checking bench for add_approx_pipe: directed corner cases, backpressure,
// random stream and an exhaustive operand sweep against an arithmetic model.
module tb_add_approx_pipe;
    localparam int WIDTH  = 8;
    localparam int MAX_K  = 4;
    localparam int STAGES = 2;
    localparam int ACC_W  = 32;
    localparam int SW     = WIDTH + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stats_clr = 1'b0;
    logic [ACC_W-1:0] err_cnt, txn_cnt, err_sum;
    logic [SW-1:0]    err_max;

    add_approx_if #(.WIDTH(WIDTH), .MAX_K(MAX_K)) bus ();

    add_approx_pipe #(.WIDTH(WIDTH), .MAX_K(MAX_K), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stats_clr(stats_clr),
        .err_cnt(err_cnt), .txn_cnt(txn_cnt), .err_sum(err_sum), .err_max(err_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfer_n = 0;
    logic [2*SW-1:0] exp_q[$];
    longint m_txn, m_errc, m_esum, m_emax;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: split operands arithmetically into high/low parts of base 2^k.
    function automatic logic [2*SW-1:0] ref_model(input int a, input int b, input int mode, input int k);
        int kk, p, ah, bh, al, bl, s, ex, e, cin;
        logic [SW-1:0] s9, e9;
        kk = (k > MAX_K) ? MAX_K : k;
        p  = 1 << kk;
        ah = a / p; bh = b / p; al = a % p; bl = b % p;
        ex = a + b;
        cin = (kk > 0) ? (((a >> (kk - 1)) & 1) & ((b >> (kk - 1)) & 1)) : 0;
        case (mode)
            0: s = ex;
            1: s = (ah + bh + cin) * p + (al | bl);
            2: s = (ah + bh) * p;
            default: s = (ah + bh) * p + ((al + bl) % p);
        endcase
        e  = (s > ex) ? s - ex : ex - s;
        s9 = s[SW-1:0];
        e9 = e[SW-1:0];
        return {s9, e9};
    endfunction

    // Scoreboard and statistics model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [2*SW-1:0] e;
        longint cap;
        cap = (64'd1 << ACC_W) - 1;
        if (!rst_n) begin
            exp_q.delete();
            m_txn = 0; m_errc = 0; m_esum = 0; m_emax = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                xfer_n++;
                e = '0;
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("sb_sum", bus.out_sum, e[2*SW-1:SW]);
                    check("sb_err", bus.out_err, e[SW-1:0]);
                end
                if (stats_clr) begin
                    m_txn = 0; m_errc = 0; m_esum = 0; m_emax = 0;
                end else begin
                    if (m_txn < cap) m_txn++;
                    if (e[SW-1:0] != 0 && m_errc < cap) m_errc++;
                    m_esum = m_esum + e[SW-1:0];
                    if (m_esum > cap) m_esum = cap;
                    if (e[SW-1:0] > m_emax) m_emax = e[SW-1:0];
                end
            end else if (stats_clr) begin
                m_txn = 0; m_errc = 0; m_esum = 0; m_emax = 0;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_mode, bus.in_k));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic drive_txn(input int a, input int b, input int mode, input int k);
        logic acc;
        int   n;
        bus.in_a = a[WIDTH-1:0]; bus.in_b = b[WIDTH-1:0];
        bus.in_mode = mode[1:0]; bus.in_k = k[2:0];
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk) acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_one(input int a, input int b, input int mode, input int k,
                            input int es, input int ee, input logic clr);
        bus.out_ready = 1'b1;
        drive_txn(a, b, mode, k);
        for (int i = 0; i < STAGES - 1; i++) begin
            check("lat_early", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        check("lat_valid", bus.out_valid, 1);
        check("dir_sum", bus.out_sum, es);
        check("dir_err", bus.out_err, ee);
        stats_clr = clr;
        @(posedge clk); #1;
        stats_clr = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_txn"}, txn_cnt, m_txn);
        check({tag, "_errc"}, err_cnt, m_errc);
        check({tag, "_esum"}, err_sum, m_esum);
        check({tag, "_emax"}, err_max, m_emax);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    logic [2*SW-1:0] first_exp;
    logic rnd_done;

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_mode = '0; bus.in_k = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_txn", txn_cnt, 0);
        check("rst_errc", err_cnt, 0);
        check("rst_esum", err_sum, 0);
        check("rst_emax", err_max, 0);

        send_one(8'h0F, 8'h01, 1, 4, 9'h00F, 1, 1'b0);
        send_one(8'h07, 8'h03, 2, 2, 9'h004, 6, 1'b0);
        send_one(8'hFF, 8'hFF, 0, 3, 9'h1FE, 0, 1'b0);
        check("st3_txn", txn_cnt, 3);
        check("st3_errc", err_cnt, 2);
        check("st3_esum", err_sum, 7);
        check("st3_emax", err_max, 6);
        send_one(8'h0F, 8'h01, 3, 4, 9'h000, 16, 1'b1);
        check("clr_txn", txn_cnt, 0);
        check("clr_errc", err_cnt, 0);
        check("clr_esum", err_sum, 0);
        check("clr_emax", err_max, 0);
        send_one(8'hFF, 8'hFF, 1, 0, 9'h1FE, 0, 1'b0);
        send_one(8'h0F, 8'h01, 1, 7, 9'h00F, 1, 1'b0);
        send_one(8'h0F, 8'h01, 3, 7, 9'h000, 16, 1'b0);

        // Backpressure: three back-to-back transactions, output held for 5 cycles.
        xfer_n = 0;
        first_exp = ref_model(8'h0F, 8'h01, 1, 4);
        fork
            begin
                drive_txn(8'h0F, 8'h01, 1, 4);
                drive_txn(8'h07, 8'h03, 2, 2);
                drive_txn(8'hA5, 8'h5A, 3, 3);
            end
            begin
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) begin
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_valid", bus.out_valid, 1);
                    check("bp_sum", bus.out_sum, first_exp[2*SW-1:SW]);
                    check("bp_err", bus.out_err, first_exp[SW-1:0]);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", xfer_n, 3);

        // Random stream with random gaps and backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    drive_txn($urandom_range(0, 255), $urandom_range(0, 255),
                              $urandom_range(0, 3), $urandom_range(0, 7));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        #1 bus.out_ready = 1'b1;
        drain();
        check_stats("rnd");

        // Reset with transactions in flight.
        drive_txn(8'h33, 8'h44, 1, 2);
        drive_txn(8'h12, 8'h34, 2, 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_sum", bus.out_sum, 0);
        check("mrst_txn", txn_cnt, 0);
        check("mrst_errc", err_cnt, 0);
        check("mrst_esum", err_sum, 0);
        check("mrst_emax", err_max, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_idle", bus.out_valid, 0);

        // Exhaustive operand sweep with random mode and k.
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                drive_txn(a, b, $urandom_range(0, 3), $urandom_range(0, 7));
        drain();
        check_stats("sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
